// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the instruction/data memory arbiter:
//   - bus widths (address, data, byte-write-enable)
//   - FSM state encoding and transaction owner encoding
//   - latched bus command struct
//   - is_load() helper (a zero write-enable mask is a read)
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WEN_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // free to grant
        ST_REQ  = 2'd1,   // bus_req high, waiting for bus_addr_ok
        ST_WAIT = 2'd2    // address accepted, waiting for bus_data_ok
    } arb_state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    typedef struct packed {
        logic [WEN_W-1:0]  wen;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } bus_cmd_t;

    function automatic logic is_load(input logic [WEN_W-1:0] wen);
        return (wen == '0);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles every non-clock signal of the arbiter:
//   fetch port   : iram_en, iram_addr -> iram_rdata, iram_stallreq
//   memory port  : dram_en, dram_wen, dram_addr, dram_wdata -> dram_rdata,
//                  dram_stallreq
//   pipeline ctl : pipe_stall, flush
//   shared bus   : bus_req, bus_wen, bus_addr, bus_wdata -> bus_addr_ok,
//                  bus_data_ok, bus_rdata
// modport master : arbiter view (drives stallreq/rdata and the bus request)
// modport slave  : pipeline + memory view (the opposite directions)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              iram_en;
    logic [ADDR_W-1:0] iram_addr;
    logic [DATA_W-1:0] iram_rdata;
    logic              iram_stallreq;

    logic              dram_en;
    logic [WEN_W-1:0]  dram_wen;
    logic [ADDR_W-1:0] dram_addr;
    logic [DATA_W-1:0] dram_wdata;
    logic [DATA_W-1:0] dram_rdata;
    logic              dram_stallreq;

    logic              pipe_stall;
    logic              flush;

    logic              bus_req;
    logic [WEN_W-1:0]  bus_wen;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        input  iram_en, iram_addr,
        output iram_rdata, iram_stallreq,
        input  dram_en, dram_wen, dram_addr, dram_wdata,
        output dram_rdata, dram_stallreq,
        input  pipe_stall, flush,
        output bus_req, bus_wen, bus_addr, bus_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport slave (
        output iram_en, iram_addr,
        input  iram_rdata, iram_stallreq,
        output dram_en, dram_wen, dram_addr, dram_wdata,
        input  dram_rdata, dram_stallreq,
        output pipe_stall, flush,
        input  bus_req, bus_wen, bus_addr, bus_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one memory bus between the fetch stage (iram) and the memory stage
// (dram). One transaction in flight at a time: IDLE grants, REQ holds bus_req
// until bus_addr_ok, WAIT waits for bus_data_ok. Results land in per-port
// buffers with a hold flag meaning "this pipeline slot already has its data".
//
// Parameters
//   DATA_FIRST : 1 = data port wins a simultaneous request, 0 = fetch wins
// Ports
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   io  : mem_arbiter_if.master (requesters, pipeline control, shared bus)
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master io
);

    arb_state_t        state;
    owner_t            owner;
    logic              hold_i, hold_d;
    logic              discard;
    logic [DATA_W-1:0] ibuf, dbuf;
    logic              bus_req_r;
    bus_cmd_t          cmd;

    logic pend_i, pend_d;
    logic grant_i, grant_d;
    logic done, keep;

    always_comb begin
        pend_i  = io.iram_en && !hold_i;
        pend_d  = io.dram_en && !hold_d;
        // A flushed fetch is never granted, so under flush the data port
        // wins regardless of priority.
        grant_d = pend_d && (DATA_FIRST || !pend_i || io.flush);
        grant_i = pend_i && !io.flush && !grant_d;
        done    = ((state == ST_REQ) && io.bus_addr_ok && io.bus_data_ok) ||
                  ((state == ST_WAIT) && io.bus_data_ok);
        // A flush on the completing edge kills the result just like a
        // flush seen earlier in the transaction.
        keep    = done && !discard && !io.flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_INST;
            hold_i    <= 1'b0;
            hold_d    <= 1'b0;
            discard   <= 1'b0;
            ibuf      <= '0;
            dbuf      <= '0;
            bus_req_r <= 1'b0;
            cmd       <= '0;
        end else begin
            // Pipeline advanced or flushed: buffered results belong to the
            // old slot. A completion below overrides this on the same edge.
            if (!io.pipe_stall || io.flush) begin
                hold_i <= 1'b0;
                hold_d <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (grant_d) begin
                        owner     <= OWN_DATA;
                        bus_req_r <= 1'b1;
                        cmd.wen   <= io.dram_wen;
                        cmd.addr  <= io.dram_addr;
                        cmd.wdata <= io.dram_wdata;
                        state     <= ST_REQ;
                    end else if (grant_i) begin
                        owner     <= OWN_INST;
                        bus_req_r <= 1'b1;
                        cmd.wen   <= '0;
                        cmd.addr  <= io.iram_addr;
                        cmd.wdata <= '0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (io.bus_addr_ok) begin
                        bus_req_r <= 1'b0;
                        state     <= io.bus_data_ok ? ST_IDLE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (io.bus_data_ok)
                        state <= ST_IDLE;
                end
                default: begin
                    bus_req_r <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase

            if (done) begin
                discard <= 1'b0;
                if (keep) begin
                    if (owner == OWN_INST) begin
                        hold_i <= 1'b1;
                        ibuf   <= io.bus_rdata;
                    end else begin
                        hold_d <= 1'b1;
                        if (is_load(cmd.wen))
                            dbuf <= io.bus_rdata;
                    end
                end
            end else if (io.flush && (state != ST_IDLE)) begin
                discard <= 1'b1;
            end
        end
    end

    assign io.iram_rdata    = ibuf;
    assign io.dram_rdata    = dbuf;
    assign io.iram_stallreq = pend_i;
    assign io.dram_stallreq = pend_d;
    assign io.bus_req       = bus_req_r;
    assign io.bus_wen       = cmd.wen;
    assign io.bus_addr      = cmd.addr;
    assign io.bus_wdata     = cmd.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed scenarios for mem_arbiter with DATA_FIRST=1. Inputs change 1ns
// after a rising edge, outputs are compared 1ns later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    mem_arbiter_if ifc ();

    mem_arbiter #(.DATA_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs;
        ifc.iram_en     = 1'b0;
        ifc.iram_addr   = '0;
        ifc.dram_en     = 1'b0;
        ifc.dram_wen    = '0;
        ifc.dram_addr   = '0;
        ifc.dram_wdata  = '0;
        ifc.pipe_stall  = 1'b0;
        ifc.flush       = 1'b0;
        ifc.bus_addr_ok = 1'b0;
        ifc.bus_data_ok = 1'b0;
        ifc.bus_rdata   = '0;
    endtask

    task automatic do_reset;
        zero_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        zero_inputs();
        rst = 1'b1;
        #2;
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req got=%h exp=0", ifc.bus_req); end
        tests++; if (ifc.bus_wen !== 4'h0) begin fails++; $display("FAIL reset_bus_wen got=%h exp=0", ifc.bus_wen); end
        tests++; if (ifc.bus_addr !== 32'h0) begin fails++; $display("FAIL reset_bus_addr got=%h exp=0", ifc.bus_addr); end
        tests++; if (ifc.bus_wdata !== 32'h0) begin fails++; $display("FAIL reset_bus_wdata got=%h exp=0", ifc.bus_wdata); end
        tests++; if (ifc.iram_rdata !== 32'h0) begin fails++; $display("FAIL reset_iram_rdata got=%h exp=0", ifc.iram_rdata); end
        tests++; if (ifc.dram_rdata !== 32'h0) begin fails++; $display("FAIL reset_dram_rdata got=%h exp=0", ifc.dram_rdata); end
        tests++; if ({ifc.iram_stallreq, ifc.dram_stallreq} !== 2'b00) begin fails++; $display("FAIL reset_stallreq got=%b exp=00", {ifc.iram_stallreq, ifc.dram_stallreq}); end
    endtask

    // Zero-wait fetch: bus_req in cycle 1, result and stallreq low in cycle 2.
    task automatic test_fetch;
        do_reset();
        tick();
        ifc.iram_en = 1'b1; ifc.iram_addr = 32'hBFC00000;
        ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h24080001;
        #1;
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL fetch_c0_stall got=%h exp=1", ifc.iram_stallreq); end
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL fetch_c0_req got=%h exp=0", ifc.bus_req); end
        tick();
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL fetch_c1_req got=%h exp=1", ifc.bus_req); end
        tests++; if (ifc.bus_addr !== 32'hBFC00000) begin fails++; $display("FAIL fetch_c1_addr got=%h exp=bfc00000", ifc.bus_addr); end
        tests++; if (ifc.bus_wen !== 4'h0) begin fails++; $display("FAIL fetch_c1_wen got=%h exp=0", ifc.bus_wen); end
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL fetch_c1_stall got=%h exp=1", ifc.iram_stallreq); end
        tick();
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL fetch_c2_req got=%h exp=0", ifc.bus_req); end
        tests++; if (ifc.iram_rdata !== 32'h24080001) begin fails++; $display("FAIL fetch_c2_rdata got=%h exp=24080001", ifc.iram_rdata); end
        tests++; if (ifc.iram_stallreq !== 1'b0) begin fails++; $display("FAIL fetch_c2_stall got=%h exp=0", ifc.iram_stallreq); end
        ifc.iram_en = 1'b0; ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0;
        tick();
    endtask

    // Simultaneous fetch + store with DATA_FIRST=1: store first, then fetch.
    task automatic test_priority;
        do_reset();
        tick();
        ifc.pipe_stall = 1'b1;
        ifc.iram_en = 1'b1; ifc.iram_addr = 32'h00000100;
        ifc.dram_en = 1'b1; ifc.dram_wen = 4'hF; ifc.dram_addr = 32'h80001000; ifc.dram_wdata = 32'hDEADBEEF;
        ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h11111111;
        #1;
        tests++; if ({ifc.iram_stallreq, ifc.dram_stallreq} !== 2'b11) begin fails++; $display("FAIL prio_c0_stall got=%b exp=11", {ifc.iram_stallreq, ifc.dram_stallreq}); end
        tick();
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL prio_c1_req got=%h exp=1", ifc.bus_req); end
        tests++; if (ifc.bus_addr !== 32'h80001000) begin fails++; $display("FAIL prio_c1_addr got=%h exp=80001000", ifc.bus_addr); end
        tests++; if (ifc.bus_wen !== 4'hF) begin fails++; $display("FAIL prio_c1_wen got=%h exp=f", ifc.bus_wen); end
        tests++; if (ifc.bus_wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL prio_c1_wdata got=%h exp=deadbeef", ifc.bus_wdata); end
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL prio_c1_istall got=%h exp=1", ifc.iram_stallreq); end
        tick();
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL prio_c2_req got=%h exp=0", ifc.bus_req); end
        tests++; if ({ifc.iram_stallreq, ifc.dram_stallreq} !== 2'b10) begin fails++; $display("FAIL prio_c2_stall got=%b exp=10", {ifc.iram_stallreq, ifc.dram_stallreq}); end
        tests++; if (ifc.dram_rdata !== 32'h0) begin fails++; $display("FAIL prio_c2_store_rdata got=%h exp=0", ifc.dram_rdata); end
        tick();
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL prio_c3_req got=%h exp=1", ifc.bus_req); end
        tests++; if (ifc.bus_addr !== 32'h00000100) begin fails++; $display("FAIL prio_c3_addr got=%h exp=00000100", ifc.bus_addr); end
        tests++; if (ifc.bus_wen !== 4'h0) begin fails++; $display("FAIL prio_c3_wen got=%h exp=0", ifc.bus_wen); end
        tick();
        tests++; if (ifc.iram_rdata !== 32'h11111111) begin fails++; $display("FAIL prio_c4_irdata got=%h exp=11111111", ifc.iram_rdata); end
        tests++; if ({ifc.iram_stallreq, ifc.dram_stallreq} !== 2'b00) begin fails++; $display("FAIL prio_c4_stall got=%b exp=00", {ifc.iram_stallreq, ifc.dram_stallreq}); end
        tests++; if (ifc.dram_rdata !== 32'h0) begin fails++; $display("FAIL prio_c4_drdata got=%h exp=0", ifc.dram_rdata); end
        zero_inputs();
        tick();
    endtask

    // Load: addr_ok 3 cycles after bus_req, data_ok 2 cycles after that.
    task automatic test_slow_load;
        do_reset();
        tick();
        ifc.dram_en = 1'b1; ifc.dram_wen = 4'h0; ifc.dram_addr = 32'h80002000;
        tick();
        ifc.dram_addr = 32'h12345678;   // must not leak onto the bus
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL slow_c%0d_req got=%h exp=1", c, ifc.bus_req); end
            tests++; if (ifc.bus_addr !== 32'h80002000) begin fails++; $display("FAIL slow_c%0d_addr got=%h exp=80002000", c, ifc.bus_addr); end
            tests++; if (ifc.dram_stallreq !== 1'b1) begin fails++; $display("FAIL slow_c%0d_stall got=%h exp=1", c, ifc.dram_stallreq); end
            tick();
        end
        ifc.bus_addr_ok = 1'b1;
        #1;
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL slow_c4_req got=%h exp=1", ifc.bus_req); end
        tick();
        ifc.bus_addr_ok = 1'b0;
        #1;
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL slow_c5_req got=%h exp=0", ifc.bus_req); end
        tests++; if (ifc.bus_addr !== 32'h80002000) begin fails++; $display("FAIL slow_c5_addr got=%h exp=80002000", ifc.bus_addr); end
        tests++; if (ifc.dram_stallreq !== 1'b1) begin fails++; $display("FAIL slow_c5_stall got=%h exp=1", ifc.dram_stallreq); end
        tick();
        ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hCAFEF00D;
        #1;
        tests++; if (ifc.dram_stallreq !== 1'b1) begin fails++; $display("FAIL slow_c6_stall got=%h exp=1", ifc.dram_stallreq); end
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        tests++; if (ifc.dram_rdata !== 32'hCAFEF00D) begin fails++; $display("FAIL slow_c7_rdata got=%h exp=cafef00d", ifc.dram_rdata); end
        tests++; if (ifc.dram_stallreq !== 1'b0) begin fails++; $display("FAIL slow_c7_stall got=%h exp=0", ifc.dram_stallreq); end
        zero_inputs();
        tick();
    endtask

    // Completion under pipe_stall: buffer and hold survive until release.
    task automatic test_hold;
        do_reset();
        tick();
        ifc.pipe_stall = 1'b1;
        ifc.iram_en = 1'b1; ifc.iram_addr = 32'h00000200;
        ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hA5A5A5A5;
        tick();
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL hold_c1_req got=%h exp=1", ifc.bus_req); end
        tick();
        ifc.bus_rdata = 32'h5A5A5A5A; ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            if (c == 5) ifc.pipe_stall = 1'b0;
            #1;
            tests++; if (ifc.iram_stallreq !== 1'b0) begin fails++; $display("FAIL hold_c%0d_stall got=%h exp=0", c, ifc.iram_stallreq); end
            tests++; if (ifc.iram_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL hold_c%0d_rdata got=%h exp=a5a5a5a5", c, ifc.iram_rdata); end
            tick();
        end
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL hold_c6_cleared got=%h exp=1", ifc.iram_stallreq); end
        tests++; if (ifc.iram_rdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL hold_c6_rdata got=%h exp=a5a5a5a5", ifc.iram_rdata); end
        zero_inputs();
        tick();
    endtask

    // Flush blocks a fetch grant; flush during WAIT discards the result.
    task automatic test_flush;
        do_reset();
        tick();
        ifc.iram_en = 1'b1; ifc.iram_addr = 32'h00000300; ifc.flush = 1'b1;
        ifc.bus_addr_ok = 1'b1; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h13572468;
        tick();
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL flush_nogrant_req got=%h exp=0", ifc.bus_req); end
        ifc.flush = 1'b0;
        tick();
        tests++; if (ifc.bus_req !== 1'b1) begin fails++; $display("FAIL flush_c2_req got=%h exp=1", ifc.bus_req); end
        tick();
        tests++; if (ifc.iram_rdata !== 32'h13572468) begin fails++; $display("FAIL flush_c3_rdata got=%h exp=13572468", ifc.iram_rdata); end
        ifc.bus_addr_ok = 1'b0; ifc.bus_data_ok = 1'b0; ifc.iram_addr = 32'h00000304;
        tick();
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL flush_c4_stall got=%h exp=1", ifc.iram_stallreq); end
        tick();
        tests++; if (ifc.bus_addr !== 32'h00000304) begin fails++; $display("FAIL flush_c5_addr got=%h exp=00000304", ifc.bus_addr); end
        ifc.bus_addr_ok = 1'b1;
        tick();
        ifc.bus_addr_ok = 1'b0; ifc.flush = 1'b1;
        #1;
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL flush_c6_req got=%h exp=0", ifc.bus_req); end
        tick();
        ifc.flush = 1'b0; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'hFFFFFFFF;
        tick();
        ifc.bus_data_ok = 1'b0;
        #1;
        tests++; if (ifc.iram_rdata !== 32'h13572468) begin fails++; $display("FAIL flush_c8_rdata got=%h exp=13572468", ifc.iram_rdata); end
        tests++; if (ifc.iram_stallreq !== 1'b1) begin fails++; $display("FAIL flush_c8_nohold got=%h exp=1", ifc.iram_stallreq); end
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL flush_c8_req got=%h exp=0", ifc.bus_req); end
        zero_inputs();
        tick();
    endtask

    // Asynchronous reset in REQ (store) and in WAIT (load).
    task automatic test_reset_mid;
        do_reset();
        tick();
        ifc.dram_en = 1'b1; ifc.dram_wen = 4'hF; ifc.dram_addr = 32'h80004000; ifc.dram_wdata = 32'h12345678;
        tick();
        tests++; if (ifc.bus_wdata !== 32'h12345678) begin fails++; $display("FAIL rmid_req_wdata got=%h exp=12345678", ifc.bus_wdata); end
        #2 rst = 1'b1;
        #1;
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL rmid_req_busreq got=%h exp=0", ifc.bus_req); end
        tests++; if (ifc.bus_wen !== 4'h0) begin fails++; $display("FAIL rmid_req_wen got=%h exp=0", ifc.bus_wen); end
        tests++; if (ifc.bus_wdata !== 32'h0) begin fails++; $display("FAIL rmid_req_wdata0 got=%h exp=0", ifc.bus_wdata); end

        do_reset();
        tick();
        ifc.dram_en = 1'b1; ifc.dram_wen = 4'h0; ifc.dram_addr = 32'h80003000;
        tick();
        ifc.bus_addr_ok = 1'b1;
        tick();
        ifc.bus_addr_ok = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL rmid_wait_busreq got=%h exp=0", ifc.bus_req); end
        tests++; if (ifc.bus_addr !== 32'h0) begin fails++; $display("FAIL rmid_wait_addr got=%h exp=0", ifc.bus_addr); end
        tests++; if (ifc.dram_stallreq !== 1'b1) begin fails++; $display("FAIL rmid_wait_stall got=%h exp=1", ifc.dram_stallreq); end
        ifc.dram_en = 1'b0; ifc.bus_data_ok = 1'b1; ifc.bus_rdata = 32'h77777777;
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests++; if (ifc.dram_rdata !== 32'h0) begin fails++; $display("FAIL rmid_no_completion got=%h exp=0", ifc.dram_rdata); end
        tests++; if (ifc.bus_req !== 1'b0) begin fails++; $display("FAIL rmid_after_req got=%h exp=0", ifc.bus_req); end
        zero_inputs();
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_slow_load();
        test_hold();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
